rf_wr_arbiter: RTL and testbench

Write-port controller for the 8-bit, 2**pw-entry register file. It shares the file's single write port between two requesters: A, the core writeback path, and B, the load/memory-return path. A round-robin arbiter decides between them. The block also sequences a zero-fill sweep of every register after reset or on command. Its registered write stage drives the register file's wr_en/wr_addr/dat_in directly and exposes the in-flight write for read bypass.

---
 rtl/rf_wr_arbiter_if.sv | 50 +++++
 rtl/rf_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wr_arbiter_if.sv
// Bundles the requester, clear, status and register-file write signals of the write-port controller.
// Latency: none; this is wiring only.
// Backpressure: a requester holds req/addr/data until it sees its gnt.
interface rf_wr_arbiter_if #(
    parameter int pw = 4,
    parameter int dw = 8
);
    // zero-fill sweep request
    logic          clr_req;

    // requester A: core writeback
    logic          a_req;
    logic [pw-1:0] a_addr;
    logic [dw-1:0] a_data;
    logic          a_gnt;

    // requester B: load / memory return
    logic          b_req;
    logic [pw-1:0] b_addr;
    logic [dw-1:0] b_data;
    logic          b_gnt;

    // status and the registered write stage toward the register file
    logic          init_busy;
    logic          rf_wr_en;
    logic [pw-1:0] rf_wr_addr;
    logic [dw-1:0] rf_wr_data;

    // requester / environment side
    modport master (
        output clr_req,
        output a_req, a_addr, a_data,
        input  a_gnt,
        output b_req, b_addr, b_data,
        input  b_gnt,
        input  init_busy,
        input  rf_wr_en, rf_wr_addr, rf_wr_data
    );

    // controller side
    modport slave (
        input  clr_req,
        input  a_req, a_addr, a_data,
        output a_gnt,
        input  b_req, b_addr, b_data,
        output b_gnt,
        output init_busy,
        output rf_wr_en, rf_wr_addr, rf_wr_data
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Shares the single register-file write port between A and B with round-robin arbitration, and runs zero-fill sweeps.
// Latency: a grant in cycle k shows on rf_wr_* in cycle k+1; the file commits at the end of cycle k+1.
// Backpressure: grants are combinational; an ungranted requester holds. There are no grants during a sweep or a clear cycle.
module rf_wr_arbiter #(
    parameter int pw = 4,
    parameter int dw = 8
) (
    input logic          i_clk,
    input logic          i_rst_n,
    rf_wr_arbiter_if.slave bus
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_ARB  = 1'b1
    } state_t;

    // Encoding of the last-grant pointer
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    // Final address of the sweep; the counter wraps to 0 after it
    localparam logic [pw-1:0] CNT_LAST = {pw{1'b1}};

    // Registered state
    state_t        r_state;
    logic [pw-1:0] r_cnt;
    logic          r_ptr;
    logic          r_wr_en;
    logic [pw-1:0] r_wr_addr;
    logic [dw-1:0] r_wr_data;

    // Next-state values and arbitration results
    state_t        w_state_nxt;
    logic [pw-1:0] w_cnt_nxt;
    logic          w_ptr_nxt;
    logic          w_wr_en_nxt;
    logic [pw-1:0] w_wr_addr_nxt;
    logic [dw-1:0] w_wr_data_nxt;
    logic          w_a_win;
    logic          w_b_win;
    logic          w_arb_open;

    // Grants only exist in ARB. A clear request closes arbitration for that cycle.
    assign w_arb_open = (r_state == S_ARB) && !bus.clr_req;

    // Round-robin choice: a lone requester wins. On a tie, the winner is the side the pointer does not name.
    always_comb begin
        w_a_win = 1'b0;
        w_b_win = 1'b0;
        if (w_arb_open) begin
            if (bus.a_req && bus.b_req) begin
                w_a_win = (r_ptr == PTR_B);
                w_b_win = (r_ptr == PTR_A);
            end else begin
                w_a_win = bus.a_req;
                w_b_win = bus.b_req;
            end
        end
    end

    // Next state for the FSM, the sweep counter, the pointer and the write stage
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;

        case (r_state)
            S_INIT: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = '0;
                if (bus.clr_req) begin
                    // Restart the sweep. Address 0 is written now and is written again by the next sweep step.
                    w_wr_addr_nxt = '0;
                    w_cnt_nxt     = '0;
                end else begin
                    w_wr_addr_nxt = r_cnt;
                    w_cnt_nxt     = r_cnt + pw'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_ARB;
                    end
                end
            end

            S_ARB: begin
                if (bus.clr_req) begin
                    // Enter a new sweep. The pointer keeps its value so fairness carries across the clear.
                    w_state_nxt   = S_INIT;
                    w_cnt_nxt     = '0;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = '0;
                    w_wr_data_nxt = '0;
                end else if (w_a_win) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = bus.a_addr;
                    w_wr_data_nxt = bus.a_data;
                    w_ptr_nxt     = PTR_A;
                end else if (w_b_win) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = bus.b_addr;
                    w_wr_data_nxt = bus.b_data;
                    w_ptr_nxt     = PTR_B;
                end
            end

            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset. Reset drops any staged write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_ptr     <= PTR_B;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // While reset is held, grants are forced low and the block reports busy, whatever state is left over.
    assign bus.a_gnt      = w_a_win & i_rst_n;
    assign bus.b_gnt      = w_b_win & i_rst_n;
    assign bus.init_busy  = (r_state == S_INIT) | ~i_rst_n;

    // The write stage drives the register file directly and also serves as the read-bypass source.
    assign bus.rf_wr_en   = r_wr_en;
    assign bus.rf_wr_addr = r_wr_addr;
    assign bus.rf_wr_data = r_wr_data;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomised and directed bench for rf_wr_arbiter, checked against a behavioural model through a write scoreboard.
// Latency: expected writes are tagged with the cycle in which they must appear on rf_wr_*.
// Backpressure: the modelled requesters hold until the model grants them.
module tb_rf_wr_arbiter;

    localparam int PW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << PW;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    exp_t exp_q[$];

    // Reference model state: sweep in progress, next sweep index, last winner (1=A, 2=B)
    bit   m_init;
    int   m_idx;
    int   m_last;

    rf_wr_arbiter_if #(.pw(PW), .dw(DW)) bus ();

    rf_wr_arbiter #(.pw(PW), .dw(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n is the cycle after the n-th rising edge that sees reset released
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int addr, input int data);
        exp_t e;
        e.cyc  = cyc + 1;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected write for every cycle in which rf_wr_en is high
    always @(negedge clk) begin
        exp_t e;
        if (bus.rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(bus.rf_wr_addr), -1);
            end else begin
                e = exp_q.pop_front();
                chk("write_cycle", cyc, e.cyc);
                chk("write_addr", int'(bus.rf_wr_addr), e.addr);
                chk("write_data", int'(bus.rf_wr_data), e.data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_write_cycle", cyc, e.cyc - 1);
        end
    end

    // One cycle: drive inputs, check grants and status against the model, then record the expected write
    task automatic step(input bit rst, input bit clr,
                        input bit ra, input int aa, input int ad,
                        input bit rb, input int ba, input int bd,
                        output int win);
        bit e_busy;
        @(negedge clk);
        rst_n       = rst;
        bus.clr_req = clr;
        bus.a_req   = ra;
        bus.a_addr  = PW'(aa);
        bus.a_data  = DW'(ad);
        bus.b_req   = rb;
        bus.b_addr  = PW'(ba);
        bus.b_data  = DW'(bd);
        #1;
        win = 0;
        if (!rst) begin
            e_busy = 1'b1;
            m_init = 1'b1;
            m_idx  = 0;
            m_last = 2;
        end else if (m_init) begin
            e_busy = 1'b1;
            if (clr) begin
                push(0, 0);
                m_idx = 0;
            end else begin
                push(m_idx, 0);
                if (m_idx == DEPTH - 1) m_init = 1'b0;
                m_idx = (m_idx + 1) % DEPTH;
            end
        end else begin
            e_busy = 1'b0;
            if (clr) begin
                push(0, 0);
                m_init = 1'b1;
                m_idx  = 0;
            end else begin
                if (ra && rb)  win = (m_last == 2) ? 1 : 2;
                else if (ra)   win = 1;
                else if (rb)   win = 2;
                if (win == 1) push(aa, ad);
                if (win == 2) push(ba, bd);
                if (win != 0) m_last = win;
            end
        end
        chk("a_gnt", int'(bus.a_gnt), (win == 1) ? 1 : 0);
        chk("b_gnt", int'(bus.b_gnt), (win == 2) ? 1 : 0);
        chk("init_busy", int'(bus.init_busy), int'(e_busy));
    endtask

    initial begin
        int w;
        int n;
        bit pa;
        bit pb;
        int paa;
        int pad;
        int pba;
        int pbd;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.clr_req = 1'b0;
        bus.a_req   = 1'b0;
        bus.b_req   = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_addr  = '0;
        bus.b_data  = '0;

        // Reset held for a few edges, then release with no requests: 16 sweep writes
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, w);
        @(negedge clk);
        chk("reset_wr_en", int'(bus.rf_wr_en), 0);
        for (int i = 0; i < 18; i++) step(1, 0, 0, 0, 0, 0, 0, 0, w);

        // A alone writes 0xA5 to address 3
        step(1, 0, 1, 3, 8'hA5, 0, 0, 0, w);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0, 0, w);

        // Both requesters held for six cycles
        for (int i = 0; i < 6; i++) step(1, 0, 1, 4 + i, 16 + i, 1, 10 + i, 32 + i, w);

        // After A's grant, B alone, then both: the tie goes to A
        step(1, 0, 1, 1, 8'h11, 0, 0, 0, w);
        step(1, 0, 0, 0, 0, 1, 2, 8'h22, w);
        step(1, 0, 1, 5, 8'h55, 1, 6, 8'h66, w);
        chk("tie_after_b_goes_to_a", w, 1);
        step(1, 0, 0, 0, 0, 1, 6, 8'h66, w);

        // Clear in ARB while A requests: A waits out the sweep and wins in the first ARB cycle
        step(1, 1, 1, 7, 8'h3C, 0, 0, 0, w);
        chk("a_blocked_by_clr", w, 0);
        n = 0;
        w = 0;
        while (w != 1 && n < 40) begin
            step(1, 0, 1, 7, 8'h3C, 0, 0, 0, w);
            n++;
        end
        chk("cycles_to_grant_after_clr", n, 17);

        // Reset while the sweep is loading address 9, then a full restart
        step(1, 1, 0, 0, 0, 0, 0, 0, w);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 0, 0, 0, w);
        step(0, 0, 0, 0, 0, 0, 0, 0, w);
        for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 0, 0, 0, 0, w);

        // Random traffic with occasional clears and resets
        pa = 0;
        pb = 0;
        paa = 0;
        pad = 0;
        pba = 0;
        pbd = 0;
        for (int i = 0; i < 800; i++) begin
            if (!pa && ($urandom % 3 != 0)) begin
                pa  = 1;
                paa = int'($urandom % DEPTH);
                pad = int'($urandom % 256);
            end
            if (!pb && ($urandom % 3 != 0)) begin
                pb  = 1;
                pba = int'($urandom % DEPTH);
                pbd = int'($urandom % 256);
            end
            step(($urandom % 150) != 0, ($urandom % 40) == 0,
                 pa, paa, pad, pb, pba, pbd, w);
            if (w == 1) pa = 0;
            if (w == 2) pb = 0;
        end

        // Drain, then confirm that every expected write appeared
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 0, w);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
